// File: rtl/jailbreak_dip_apply_pkg.sv
// Shared DIP switch types and the settle/apply state encoding used by the
// bridge-side consumer that applies switch changes to the emulated core.
package jailbreak;

  typedef logic [7:0] dip_switch_t;

  localparam dip_switch_t dip_switch_default = 8'h00;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    WAIT_OK = 2'd2,
    HOLD    = 2'd3
  } dip_apply_state_e;

  localparam int DIP_SETTLE_CYCLES = 1024;
  localparam int DIP_RESET_CYCLES  = 16;

  function automatic int dip_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/jailbreak_dip_apply.sv
// Debounces the bridge-written DIP vector, waits for a core safe point, then
// latches the new vector and holds the core in reset for a fixed pulse.
module jailbreak_dip_apply
  import jailbreak::*;
#(
  parameter int SETTLE_CYCLES = DIP_SETTLE_CYCLES,
  parameter int RESET_CYCLES  = DIP_RESET_CYCLES
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [$bits(dip_switch_t)-1:0] dip_switches_in,
  input  logic                      apply_ok,
  output logic [$bits(dip_switch_t)-1:0] dip_switches_out,
  output logic                      core_reset,
  output logic                      apply_busy,
  output logic [7:0]                apply_count
);

  localparam int CNT_MAX = dip_max(SETTLE_CYCLES, RESET_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RESET_LAST  = CNT_W'(RESET_CYCLES - 1);

  if (SETTLE_CYCLES < 1 || RESET_CYCLES < 1) begin : g_param_check
    $error("jailbreak_dip_apply: SETTLE_CYCLES and RESET_CYCLES must be >= 1");
  end

  dip_apply_state_e state;
  logic [CNT_W-1:0] counter;
  dip_switch_t      candidate;

  assign apply_busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= HOLD;
      counter          <= '0;
      core_reset       <= 1'b1;
      dip_switches_out <= dip_switch_default;
      candidate        <= dip_switch_default;
      apply_count      <= 8'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (dip_switches_in != dip_switches_out) begin
            candidate <= dip_switches_in;
            counter   <= '0;
            state     <= SETTLE;
          end
        end

        SETTLE: begin
          // Any bounce to a third value restarts the stability window.
          if (dip_switches_in == dip_switches_out) begin
            state <= IDLE;
          end else if (dip_switches_in != candidate) begin
            candidate <= dip_switches_in;
            counter   <= '0;
          end else if (counter == SETTLE_LAST) begin
            state <= WAIT_OK;
          end else begin
            counter <= counter + 1'b1;
          end
        end

        WAIT_OK: begin
          // Input stability takes priority over the safe-point handshake.
          if (dip_switches_in == dip_switches_out) begin
            state <= IDLE;
          end else if (dip_switches_in != candidate) begin
            candidate <= dip_switches_in;
            counter   <= '0;
            state     <= SETTLE;
          end else if (apply_ok) begin
            dip_switches_out <= candidate;
            core_reset       <= 1'b1;
            counter          <= '0;
            apply_count      <= apply_count + 8'd1;
            state            <= HOLD;
          end
        end

        HOLD: begin
          // Inputs are ignored here; IDLE picks up any pending change.
          if (counter == RESET_LAST) begin
            core_reset <= 1'b0;
            counter    <= '0;
            state      <= IDLE;
          end else begin
            counter <= counter + 1'b1;
          end
        end

        default: begin
          state      <= HOLD;
          counter    <= '0;
          core_reset <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jailbreak_dip_apply.sv
// Scoreboard bench: a run-length reference model predicts every cycle's
// outputs; a separate monitor pops and compares after each clock edge.
module tb_jailbreak_dip_apply;
  import jailbreak::*;

  localparam int S = 8;
  localparam int R = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        apply_ok = 1'b0;
  dip_switch_t din = dip_switch_default;
  dip_switch_t dout;
  logic        core_reset;
  logic        apply_busy;
  logic [7:0]  apply_count;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  jailbreak_dip_apply #(.SETTLE_CYCLES(S), .RESET_CYCLES(R)) dut (
    .clk              (clk),
    .reset            (reset),
    .dip_switches_in  (din),
    .apply_ok         (apply_ok),
    .dip_switches_out (dout),
    .core_reset       (core_reset),
    .apply_busy       (apply_busy),
    .apply_count      (apply_count)
  );

  typedef struct {
    dip_switch_t out;
    logic        crst;
    logic        busy;
    logic [7:0]  cnt;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: an apply fires once the input has held one value
  // (different from the output) for S+2 consecutive non-hold samples and
  // apply_ok is high; the core then sits in reset for R cycles.
  dip_switch_t m_out = dip_switch_default;
  logic [7:0]  m_cnt = 8'd0;
  int          m_hold = 0;
  int          m_run = 0;
  dip_switch_t m_last = dip_switch_default;

  always @(posedge clk) begin
    exp_t e;
    if (reset) begin
      m_out  = dip_switch_default;
      m_cnt  = 8'd0;
      m_hold = R;
      m_run  = 0;
    end else if (m_hold > 0) begin
      m_hold = m_hold - 1;
      m_run  = 0;
    end else begin
      if (din == m_out) m_run = 0;
      else if (m_run > 0 && din == m_last) m_run = m_run + 1;
      else m_run = 1;
      if (m_run >= S + 2 && apply_ok) begin
        m_out  = din;
        m_cnt  = m_cnt + 8'd1;
        m_hold = R;
        m_run  = 0;
      end
    end
    m_last = din;
    e.out  = m_out;
    e.crst = (m_hold > 0);
    e.busy = (m_hold > 0) || (m_run > 0);
    e.cnt  = m_cnt;
    exp_q.push_back(e);
  end

  always @(posedge clk) begin
    exp_t e;
    #1;
    n_checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL scoreboard_empty t=%0t: no expected entry queued", $time);
    end else begin
      e = exp_q.pop_front();
      if (dout === e.out && core_reset === e.crst && apply_busy === e.busy &&
          apply_count === e.cnt) begin
        n_pass++;
      end else begin
        $display("FAIL cycle_outputs t=%0t: got out=%h crst=%b busy=%b cnt=%0d, expected out=%h crst=%b busy=%b cnt=%0d",
                 $time, dout, core_reset, apply_busy, apply_count,
                 e.out, e.crst, e.busy, e.cnt);
      end
    end
  end

  task automatic drive(input dip_switch_t v, input logic ok, input logic r, input int n);
    repeat (n) begin
      @(negedge clk);
      din      = v;
      apply_ok = ok;
      reset    = r;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic do_reset();
    drive(dip_switch_default, 1'b0, 1'b1, 2);
    drive(dip_switch_default, 1'b0, 1'b0, R + 2);
  endtask

  initial begin
    dip_switch_t vals [4];
    dip_switch_t cur;
    vals[0] = dip_switch_default;
    vals[1] = 8'h05;
    vals[2] = 8'h06;
    vals[3] = 8'h07;

    // Power-on
    drive(dip_switch_default, 1'b0, 1'b1, 3);
    drive(dip_switch_default, 1'b0, 0, R + 2);
    check("por_core_reset", int'(core_reset), 0);
    check("por_busy", int'(apply_busy), 0);
    check("por_out", int'(dout), int'(dip_switch_default));
    check("por_count", int'(apply_count), 0);

    // Clean change
    drive(8'h05, 1'b1, 1'b0, 20);
    check("clean_out", int'(dout), 5);
    check("clean_count", int'(apply_count), 1);

    // Bounce restarts the window
    do_reset();
    drive(8'h05, 1'b1, 1'b0, 4);
    drive(8'h06, 1'b1, 1'b0, 20);
    check("bounce_out", int'(dout), 6);
    check("bounce_count", int'(apply_count), 1);

    // Revert before settling
    do_reset();
    drive(8'h05, 1'b1, 1'b0, 3);
    drive(dip_switch_default, 1'b1, 1'b0, 15);
    check("revert_out", int'(dout), int'(dip_switch_default));
    check("revert_count", int'(apply_count), 0);

    // Gated by apply_ok
    drive(8'h05, 1'b0, 1'b0, 30);
    check("gate_busy", int'(apply_busy), 1);
    check("gate_out", int'(dout), int'(dip_switch_default));
    drive(8'h05, 1'b1, 1'b0, 10);
    check("gate_out_after", int'(dout), 5);

    // Change while core_reset is high
    do_reset();
    drive(8'h05, 1'b1, 1'b0, 11);
    drive(8'h07, 1'b1, 1'b0, 30);
    check("hold_change_out", int'(dout), 7);
    check("hold_change_count", int'(apply_count), 2);

    // Reset in the middle of HOLD
    do_reset();
    drive(8'h05, 1'b1, 1'b0, 13);
    drive(8'h05, 1'b1, 1'b1, 2);
    check("midhold_out", int'(dout), int'(dip_switch_default));
    check("midhold_crst", int'(core_reset), 1);
    check("midhold_count", int'(apply_count), 0);

    // 256 applies wrap the counter
    do_reset();
    for (int i = 0; i < 256; i++) drive((i % 2 == 0) ? 8'h05 : 8'h06, 1'b1, 1'b0, 16);
    drive(8'h06, 1'b1, 1'b0, 4);
    check("wrap_count", int'(apply_count), 0);
    check("wrap_out", int'(dout), 6);

    // Randomized traffic
    do_reset();
    cur = dip_switch_default;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 11) == 0) cur = vals[$urandom_range(0, 3)];
      drive(cur, ($urandom_range(0, 3) != 0), ($urandom_range(0, 499) == 0), 1);
    end

    drive(dip_switch_default, 1'b0, 1'b0, 3);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/jailbreak_dip_apply.md
Name: jailbreak_dip_apply

Overview:
- Downstream consumer of the bridge-written DIP switch register; takes the raw `jailbreak::dip_switch_t` vector and applies it to the emulated core safely.
- A new value is applied only after it has stayed stable for `SETTLE_CYCLES` and the core signals a safe point (`apply_ok`).
- The new value is then latched and the core is held in reset for `RESET_CYCLES`, so the core never sees a partially written or bouncing configuration.

Parameters:
- SETTLE_CYCLES, 1024, cycles the input must stay unchanged before an apply is armed (>=1).
- RESET_CYCLES, 16, cycles `core_reset` is held after an apply (>=1).

Ports:
- clk  input  1  core clock.
- reset  input  1  synchronous, active-high reset.
- dip_switches_in  input  $bits(jailbreak::dip_switch_t)  raw switch vector from the bridge register.
- apply_ok  input  1  core at a safe point (e.g. vblank); an apply may start this cycle.
- dip_switches_out  output  $bits(jailbreak::dip_switch_t)  applied switch vector, registered.
- core_reset  output  1  reset to the core, registered.
- apply_busy  output  1  high whenever state != IDLE, registered/derived from state reg.
- apply_count  output  8  number of applies performed, wraps 255->0.

Behaviour:
- One clock; reset is synchronous and active-high.
- All outputs are registered.
- Reset values while `reset`=1:
  - state=HOLD, counter=0, core_reset=1.
  - dip_switches_out=jailbreak::dip_switch_default, candidate=jailbreak::dip_switch_default.
  - apply_count=0.
- After reset releases, `core_reset` stays high for exactly RESET_CYCLES further cycles, then the block enters IDLE. This power-on hold does not increment `apply_count`.
- State IDLE:
  - core_reset=0.
  - If dip_switches_in != dip_switches_out: candidate<=in, counter<=0, go to SETTLE.
- State SETTLE:
  - If in == dip_switches_out: go to IDLE (change reverted).
  - Else if in != candidate: candidate<=in, counter<=0, stay in SETTLE (bounce restarts the window).
  - Else if counter == SETTLE_CYCLES-1: go to WAIT_OK.
  - Else counter++.
- State WAIT_OK:
  - Input checks run before `apply_ok`: in == out goes to IDLE; in != candidate goes to SETTLE with the new candidate and counter=0.
  - Else if apply_ok: dip_switches_out<=candidate, core_reset<=1, counter<=0, apply_count++, go to HOLD.
- State HOLD:
  - core_reset=1; input changes are ignored.
  - When counter == RESET_CYCLES-1: core_reset<=0, go to IDLE. Else counter++.
  - A change pending at HOLD exit is detected by IDLE on the next cycle.
- Latency: the input changes and is first sampled different in cycle 0.
  - SETTLE is entered in cycle 1.
  - WAIT_OK is entered in cycle 1+SETTLE_CYCLES.
  - With apply_ok already high, dip_switches_out updates and core_reset rises together in cycle 2+SETTLE_CYCLES.
  - core_reset is high for exactly RESET_CYCLES cycles.
- dip_switches_out changes only on the WAIT_OK->HOLD transition or on reset.
- Counter width is $clog2(max(SETTLE_CYCLES,RESET_CYCLES)+1). No overflow is possible.
- Reset mid-operation aborts any state and restarts the power-on HOLD. The pending candidate is discarded.
- Elaboration assertion: SETTLE_CYCLES>=1 and RESET_CYCLES>=1.

Decomposition:
- Package `jailbreak`:
  - Add enum `dip_apply_state_e` {IDLE, SETTLE, WAIT_OK, HOLD}.
  - Add default constants DIP_SETTLE_CYCLES and DIP_RESET_CYCLES.
  - Reuse the existing dip_switch_t and dip_switch_default.
- Single module; no sub-module warranted.
- The instance sits between the DIP bridge register and the core top.

Test Plan (bench uses SETTLE_CYCLES=8, RESET_CYCLES=4):
- Power-on: reset high 3 cycles, in=default -> core_reset=1 during reset plus 4 cycles after, out=default, apply_count=0, apply_busy drops with core_reset.
- Clean change: apply_ok=1, in goes to 0x5 at cycle 0 and holds -> out=0x5 and core_reset rise at cycle 10, core_reset high cycles 10-13, apply_count=1.
- Bounce: in=0x5 at cycle 0, 0x6 at cycle 4, then stable -> window restarts; out=0x6 at cycle 14; 0x5 is never output; apply_count increments once.
- Revert and gating, two sub-cases:
  - in=0x5 for 3 cycles, then back to default -> returns to IDLE, no reset pulse, apply_count unchanged.
  - apply_ok=0 with stable 0x5 -> stays in WAIT_OK, apply_busy=1; out updates the cycle after apply_ok=1.
- Change during HOLD: in changes 0x5->0x7 while core_reset=1 -> pulse completes unaltered (4 cycles); 0x7 is then settled and applied as a second pulse; apply_count=2.
- Reset mid-HOLD, plus wrap: assert reset during HOLD -> out=default, core_reset held, apply_count=0. Separately, 256 applies -> apply_count wraps to 0.
